// File: rtl/mem_responder_pkg.sv
// Shared types and default sizes for the memory responder and the datapath MAR/MDR.
package mem_responder_pkg;

    localparam int MEM_ADDR_W      = 9;
    localparam int MEM_DATA_W      = 32;
    localparam int MEM_DEPTH       = 512;
    localparam int MEM_WAIT_CYCLES = 2;
    localparam int WAIT_CNT_W      = 4;

    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_ACCESS,
        MS_DONE
    } mem_state_t;

    // Counter preload: the WAIT state is skipped entirely when no wait states are requested.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int cycles);
        return (cycles == 0) ? '0 : WAIT_CNT_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side strobe/ready bus between the control unit and the memory responder.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
);
    // Four-phase handshake: the master raises exactly one of read/write with address and
    // wr_data stable; the slave answers with mem_ready, which stays high until both strobes
    // are seen low. A new request is only taken once mem_ready has dropped again.
    logic              read;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] wr_data;
    logic [DATA_W-1:0] rd_data;
    logic              mem_ready;
    logic              busy;
    logic              err;

    modport master (
        output read, write, address, wr_data,
        input  rd_data, mem_ready, busy, err
    );

    modport slave (
        input  read, write, address, wr_data,
        output rd_data, mem_ready, busy, err
    );

endinterface

// File: rtl/mem_responder_mem_array.sv
// Single-port synchronous word RAM; the read register is cleared by reset, the array is not.
module mem_responder_mem_array #(
    parameter int DEPTH  = 512,
    parameter int DATA_W = 32,
    parameter int AW     = 9
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (en_i && !we_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a Read/Write strobe, waits WAIT_CYCLES, performs one word
// access and holds Mem_Ready until the control unit drops both strobes.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_W      = MEM_ADDR_W,
    parameter int DATA_W      = MEM_DATA_W,
    parameter int DEPTH       = MEM_DEPTH,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_responder_if.slave   bus,
    output mem_state_t       state_o
);

    localparam int                    MEM_AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]       DEPTH_LIM = (ADDR_W + 1)'(DEPTH);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    mem_state_t              state_q, state_d;
    logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [DATA_W-1:0]       wdata_q, wdata_d;
    logic                    op_wr_q, op_wr_d;
    logic                    err_q, err_d;
    logic                    rd_zero_q, rd_zero_d;

    logic                    in_range;
    logic                    ram_en;
    logic [DATA_W-1:0]       ram_rdata;

    assign in_range = ({1'b0, addr_q} < DEPTH_LIM);
    assign ram_en   = (state_q == MS_ACCESS) && in_range;

    mem_responder_mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .AW     (MEM_AW)
    ) u_array (
        .clk     (clk),
        .rst_n   (rst_n),
        .en_i    (ram_en),
        .we_i    (op_wr_q),
        .addr_i  (addr_q[MEM_AW-1:0]),
        .wdata_i (wdata_q),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MS_IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            op_wr_q   <= 1'b0;
            err_q     <= 1'b0;
            rd_zero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            op_wr_q   <= op_wr_d;
            err_q     <= err_d;
            rd_zero_q <= rd_zero_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        op_wr_d   = op_wr_q;
        err_d     = 1'b0;
        rd_zero_d = rd_zero_q;

        unique case (state_q)
            MS_IDLE: begin
                if (bus.read ^ bus.write) begin
                    addr_d  = bus.address;
                    wdata_d = bus.wr_data;
                    op_wr_d = bus.write;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_CYCLES == 0) ? MS_ACCESS : MS_WAIT;
                end else if (bus.read && bus.write) begin
                    // Conflicting strobes complete the handshake without touching the array.
                    state_d = MS_DONE;
                    err_d   = 1'b1;
                end
            end
            MS_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = MS_ACCESS;
                end else begin
                    cnt_d = cnt_q - WAIT_CNT_W'(1);
                end
            end
            MS_ACCESS: begin
                state_d = MS_DONE;
                err_d   = !in_range;
                // An out-of-range read reports zero instead of the stale RAM register.
                if (!op_wr_q) begin
                    rd_zero_d = !in_range;
                end
            end
            MS_DONE: begin
                if (!bus.read && !bus.write) begin
                    state_d = MS_IDLE;
                end
            end
            default: state_d = MS_IDLE;
        endcase
    end

    assign bus.rd_data   = rd_zero_q ? '0 : ram_rdata;
    assign bus.mem_ready = (state_q == MS_DONE);
    assign bus.busy      = (state_q == MS_WAIT) || (state_q == MS_ACCESS);
    assign bus.err       = err_q;
    assign state_o       = state_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed handshake scenarios plus randomized traffic against a word-level model.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int ADDR_W      = 9;
    localparam int DATA_W      = 32;
    localparam int DEPTH       = 256;
    localparam int WAIT_CYCLES = 2;
    localparam int LAT         = WAIT_CYCLES + 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    mem_state_t dbg_state;
    mem_responder_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_responder #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (dbg_state)
    );

    // ---------------- scoreboard / model ----------------
    int total = 0;
    int bad   = 0;
    logic [DATA_W-1:0] model_mem [int];
    logic [DATA_W-1:0] model_rd;
    logic [DATA_W-1:0] exp_q [$];

    int                lat, busy_bad, err_early;
    logic              err_rdy, rel_rdy, rel_busy, rel_err;
    logic [DATA_W-1:0] rdv, exp_v;

    // Word-level view: a read returns the stored word (zero out of range), a legal write
    // stores, conflicting strobes change nothing. Returns the RdData expected afterwards.
    function automatic logic [DATA_W-1:0] predict(input logic rd, input logic wr, input int a,
                                                   input logic [DATA_W-1:0] d);
        if (rd && !wr) begin
            model_rd = (a < DEPTH) ? model_mem[a] : '0;
        end else if (wr && !rd && a < DEPTH) begin
            model_mem[a] = d;
        end
        return model_rd;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d, output int n_lat, output logic e_rdy,
                         output logic [DATA_W-1:0] r_val, output int b_bad, output int e_early);
        n_lat = -1; e_rdy = 1'b0; r_val = '0; b_bad = 0; e_early = 0;
        @(posedge clk); #1;
        bus.read = rd; bus.write = wr; bus.address = a; bus.wr_data = d;
        for (int n = 1; n <= 64; n++) begin
            @(posedge clk); #1;
            if (bus.mem_ready) begin
                n_lat = n - 1; e_rdy = bus.err; r_val = bus.rd_data;
                break;
            end
            if (!bus.busy) b_bad++;
            if (bus.err) e_early++;
        end
    endtask

    task automatic release_req(output logic rdy, output logic bsy, output logic er);
        bus.read = 1'b0; bus.write = 1'b0;
        @(posedge clk); #1;
        rdy = bus.mem_ready; bsy = bus.busy; er = bus.err;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        total++; if (bus.rd_data !== '0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
        total++; if ({bus.mem_ready, bus.busy, bus.err} !== 3'b000) begin bad++; $display("FAIL reset_flags: got %b want 000", {bus.mem_ready, bus.busy, bus.err}); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (dbg_state !== MS_IDLE) begin bad++; $display("FAIL reset_state: got %0d want %0d", dbg_state, MS_IDLE); end
        total++; if ({bus.mem_ready, bus.busy, bus.err} !== 3'b000) begin bad++; $display("FAIL idle_flags: got %b want 000", {bus.mem_ready, bus.busy, bus.err}); end
    endtask

    task automatic test_write_read();
        exp_v = predict(1'b0, 1'b1, 'h055, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 9'h055, 32'hDEADBEEF, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (lat !== LAT) begin bad++; $display("FAIL wr_latency: got %0d want %0d", lat, LAT); end
        total++; if (err_rdy !== 1'b0) begin bad++; $display("FAIL wr_err: got %b want 0", err_rdy); end
        total++; if (busy_bad !== 0) begin bad++; $display("FAIL wr_busy: got %0d idle cycles want 0", busy_bad); end
        release_req(rel_rdy, rel_busy, rel_err);
        total++; if ({rel_rdy, rel_busy} !== 2'b00) begin bad++; $display("FAIL wr_release: got %b want 00", {rel_rdy, rel_busy}); end
        exp_q.push_back(predict(1'b1, 1'b0, 'h055, '0));
        issue(1'b1, 1'b0, 9'h055, '0, lat, err_rdy, rdv, busy_bad, err_early);
        exp_v = exp_q.pop_front();
        total++; if (lat !== LAT) begin bad++; $display("FAIL rd_latency: got %0d want %0d", lat, LAT); end
        total++; if (rdv !== 32'hDEADBEEF || rdv !== exp_v) begin bad++; $display("FAIL rd_data: got %h want %h", rdv, 32'hDEADBEEF); end
        release_req(rel_rdy, rel_busy, rel_err);
    endtask

    task automatic test_rw_conflict();
        exp_v = predict(1'b0, 1'b1, 'h010, 32'hA5A50010);
        issue(1'b0, 1'b1, 9'h010, 32'hA5A50010, lat, err_rdy, rdv, busy_bad, err_early);
        release_req(rel_rdy, rel_busy, rel_err);
        exp_v = predict(1'b1, 1'b1, 'h010, 32'h0BAD0BAD);
        issue(1'b1, 1'b1, 9'h010, 32'h0BAD0BAD, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (lat !== 0) begin bad++; $display("FAIL rw_latency: got %0d want 0", lat); end
        total++; if (err_rdy !== 1'b1) begin bad++; $display("FAIL rw_err: got %b want 1", err_rdy); end
        total++; if (rdv !== exp_v) begin bad++; $display("FAIL rw_rd_data: got %h want %h", rdv, exp_v); end
        release_req(rel_rdy, rel_busy, rel_err);
        total++; if ({rel_rdy, rel_err} !== 2'b00) begin bad++; $display("FAIL rw_err_pulse: got %b want 00", {rel_rdy, rel_err}); end
        exp_v = predict(1'b1, 1'b0, 'h010, '0);
        issue(1'b1, 1'b0, 9'h010, '0, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (rdv !== 32'hA5A50010) begin bad++; $display("FAIL rw_array_kept: got %h want %h", rdv, 32'hA5A50010); end
        release_req(rel_rdy, rel_busy, rel_err);
    endtask

    task automatic test_out_of_range();
        exp_v = predict(1'b0, 1'b1, 'h0FF, 32'h000000FF);
        issue(1'b0, 1'b1, 9'h0FF, 32'h000000FF, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (err_rdy !== 1'b0) begin bad++; $display("FAIL top_word_err: got %b want 0", err_rdy); end
        release_req(rel_rdy, rel_busy, rel_err);
        exp_v = predict(1'b0, 1'b1, 'h1FF, 32'h12345678);
        issue(1'b0, 1'b1, 9'h1FF, 32'h12345678, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (lat !== LAT) begin bad++; $display("FAIL oor_wr_latency: got %0d want %0d", lat, LAT); end
        total++; if (err_rdy !== 1'b1 || err_early !== 0) begin bad++; $display("FAIL oor_wr_err: got %b/%0d want 1/0", err_rdy, err_early); end
        release_req(rel_rdy, rel_busy, rel_err);
        total++; if (rel_err !== 1'b0) begin bad++; $display("FAIL oor_err_pulse: got %b want 0", rel_err); end
        exp_v = predict(1'b1, 1'b0, 'h0FF, '0);
        issue(1'b1, 1'b0, 9'h0FF, '0, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (rdv !== exp_v) begin bad++; $display("FAIL oor_no_alias: got %h want %h", rdv, exp_v); end
        release_req(rel_rdy, rel_busy, rel_err);
        exp_v = predict(1'b1, 1'b0, DEPTH, '0);
        issue(1'b1, 1'b0, 9'(DEPTH), '0, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (rdv !== '0 || err_rdy !== 1'b1) begin bad++; $display("FAIL oor_rd: got %h/%b want 0/1", rdv, err_rdy); end
        release_req(rel_rdy, rel_busy, rel_err);
    endtask

    task automatic test_hold_read();
        exp_v = predict(1'b1, 1'b0, 'h055, '0);
        issue(1'b1, 1'b0, 9'h055, '0, lat, err_rdy, rdv, busy_bad, err_early);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            total++;
            if ({bus.mem_ready, bus.busy, bus.err} !== 3'b100 || bus.rd_data !== exp_v) begin
                bad++; $display("FAIL hold_read: cycle %0d got rdy/busy/err=%b data=%h want 100 %h", k, {bus.mem_ready, bus.busy, bus.err}, bus.rd_data, exp_v);
            end
        end
        release_req(rel_rdy, rel_busy, rel_err);
        total++; if ({rel_rdy, rel_busy} !== 2'b00) begin bad++; $display("FAIL hold_release: got %b want 00", {rel_rdy, rel_busy}); end
    endtask

    task automatic test_reset_mid_op();
        exp_v = predict(1'b0, 1'b1, 'h020, 32'h0000_0020);
        issue(1'b0, 1'b1, 9'h020, 32'h0000_0020, lat, err_rdy, rdv, busy_bad, err_early);
        release_req(rel_rdy, rel_busy, rel_err);
        exp_v = predict(1'b1, 1'b0, 'h055, '0);
        issue(1'b1, 1'b0, 9'h055, '0, lat, err_rdy, rdv, busy_bad, err_early);
        release_req(rel_rdy, rel_busy, rel_err);
        @(posedge clk); #1;
        bus.write = 1'b1; bus.address = 9'h020; bus.wr_data = 32'hFEEDFACE;
        @(posedge clk); #1;
        @(posedge clk); #1;
        total++; if (dbg_state !== MS_WAIT || bus.busy !== 1'b1) begin bad++; $display("FAIL mid_wait: got state %0d busy %b want %0d 1", dbg_state, bus.busy, MS_WAIT); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (dbg_state !== MS_IDLE) begin bad++; $display("FAIL mid_reset_state: got %0d want %0d", dbg_state, MS_IDLE); end
        total++; if (bus.rd_data !== '0 || bus.busy !== 1'b0) begin bad++; $display("FAIL mid_reset_out: got %h/%b want 0/0", bus.rd_data, bus.busy); end
        bus.write = 1'b0;
        model_rd = '0;
        @(posedge clk); #3;
        rst_n = 1'b1;
        exp_v = predict(1'b1, 1'b0, 'h020, '0);
        issue(1'b1, 1'b0, 9'h020, '0, lat, err_rdy, rdv, busy_bad, err_early);
        total++; if (rdv !== 32'h0000_0020 || rdv !== exp_v) begin bad++; $display("FAIL mid_reset_array: got %h want %h", rdv, 32'h0000_0020); end
        release_req(rel_rdy, rel_busy, rel_err);
    endtask

    task automatic test_random();
        logic [ADDR_W-1:0] pool [6];
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic              rd, wr;
        int                kind, exp_lat;
        logic              exp_err;
        for (int i = 0; i < 6; i++) begin
            pool[i] = ADDR_W'($urandom_range(0, DEPTH - 1));
            d = $urandom;
            exp_v = predict(1'b0, 1'b1, int'(pool[i]), d);
            issue(1'b0, 1'b1, pool[i], d, lat, err_rdy, rdv, busy_bad, err_early);
            release_req(rel_rdy, rel_busy, rel_err);
        end
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 9);
            a    = pool[$urandom_range(0, 5)];
            d    = $urandom;
            rd   = (kind >= 6) || (kind == 0) || (kind == 1 && d[0]);
            wr   = (kind >= 2 && kind <= 5) || (kind == 0) || (kind == 1 && !d[0]);
            if (kind == 1) a = ADDR_W'($urandom_range(DEPTH, (1 << ADDR_W) - 1));
            exp_err = (rd && wr) || (int'(a) >= DEPTH);
            exp_lat = (rd && wr) ? 0 : WAIT_CYCLES + 1;
            exp_q.push_back(predict(rd, wr, int'(a), d));
            issue(rd, wr, a, d, lat, err_rdy, rdv, busy_bad, err_early);
            exp_v = exp_q.pop_front();
            total++; if (lat !== exp_lat) begin bad++; $display("FAIL rnd_latency[%0d]: got %0d want %0d", i, lat, exp_lat); end
            total++; if (err_rdy !== exp_err || err_early !== 0) begin bad++; $display("FAIL rnd_err[%0d]: got %b/%0d want %b/0", i, err_rdy, err_early, exp_err); end
            total++; if (rdv !== exp_v) begin bad++; $display("FAIL rnd_rd_data[%0d]: got %h want %h (rd=%b wr=%b a=%h)", i, rdv, exp_v, rd, wr, a); end
            total++; if (busy_bad !== 0) begin bad++; $display("FAIL rnd_busy[%0d]: got %0d idle cycles want 0", i, busy_bad); end
            release_req(rel_rdy, rel_busy, rel_err);
            total++; if ({rel_rdy, rel_busy, rel_err} !== 3'b000) begin bad++; $display("FAIL rnd_release[%0d]: got %b want 000", i, {rel_rdy, rel_busy, rel_err}); end
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst_n = 1'b0;
        bus.read = 1'b0; bus.write = 1'b0; bus.address = '0; bus.wr_data = '0;
        model_rd = '0;
        test_reset();
        test_write_read();
        test_rw_conflict();
        test_out_of_range();
        test_hold_read();
        test_reset_mid_op();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
